add_sub_bist: RTL and testbench
===============================

ADD_SUB_BIST -- requirements
Module: add_sub_bist

Interface
REQ-001 SHALL have parameter: SETTLE, default 1, number of idle cycles (1..15) between driving a vector and sampling the DUT response.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  begin a full sweep; sampled only in IDLE.
REQ-005 SHALL have port: busy  output  1  sweep in progress.
REQ-006 SHALL have port: done  output  1  sweep finished; sticky until next accepted start or reset.
REQ-007 SHALL have port: pass  output  1  valid with done; 1 iff err_cnt==0.
REQ-008 SHALL have port: err_cnt  output  10  number of failing vectors (0..512).
REQ-009 SHALL have ports: dut_a, dut_b  output  4 each  operands to adder/subtractor under test.
REQ-010 SHALL have port: dut_in_c  output  1  0 = add, 1 = subtract.
REQ-011 SHALL have ports: dut_s  input  4; dut_overflow, dut_zero, dut_out_c  input  1 each  DUT response.
REQ-012 SHALL have ports: fail_a, fail_b  output  4 each; fail_in_c  output  1; fail_valid  output  1  first failing vector.

Function
REQ-013 SHALL sweep vector index v[8:0] = {in_c, a, b} from 0 to 511 ascending, exactly once per sweep.
REQ-014 SHALL use FSM states IDLE, DRIVE, WAIT, CHECK, DONE: IDLE -start-> DRIVE -> WAIT (SETTLE cycles) -> CHECK -> DRIVE (v<511, v increments) or DONE (v==511); DONE -start-> DRIVE with cleared counters.
REQ-015 SHALL hold dut_a/dut_b/dut_in_c stable from DRIVE through CHECK of each vector.
REQ-016 SHALL compute expected: b' = in_c ? ~b : b; 5-bit sum = a + b' + in_c; s = sum[3:0]; out_c = sum[4]; overflow = (a[3]==b'[3]) && (s[3]!=a[3]); zero = (s==0).
REQ-017 SHALL count a vector as failing once if any of s, overflow, zero, out_c mismatches in CHECK.
REQ-018 SHALL make each vector take SETTLE+2 cycles; done rises 512*(SETTLE+2) cycles after the edge that accepted start.
REQ-019 SHALL assert busy in DRIVE/WAIT/CHECK only; done and busy never both 1.
REQ-020 SHALL ignore start while busy; start held high in DONE restarts exactly one new sweep.
REQ-021 SHALL never wrap err_cnt (max 512 fits 10 bits).

Reset
REQ-022 SHALL on rst_n low, at any time including mid-sweep, immediately go to IDLE with busy=0, done=0, pass=0, err_cnt=0, dut_a=dut_b=0, dut_in_c=0, fail_*=0.
REQ-023 SHALL require a new start after reset release; no sweep resumes.

Configuration
REQ-024 SHALL with ADD_SUB_BIST_FIRST_FAIL_EN defined capture a, b, in_c of the first failing vector of a sweep into fail_a/fail_b/fail_in_c and set fail_valid; later failures do not overwrite; cleared on accepted start.
REQ-025 SHALL without ADD_SUB_BIST_FIRST_FAIL_EN drive fail_a, fail_b, fail_in_c, fail_valid constant 0 with no capture registers.

Structure
REQ-026 SHALL place FSM state enum, vector count constant (512) and operand width (4) in shared package add_sub_pkg.
REQ-027 SHALL implement the expected-result computation as one combinational sub-module add_sub_ref; existing add_sub is instantiated at top level by the bench, not inside this block.

Verification
REQ-028 SHALL cover: correct add_sub connected, SETTLE=1, start pulse -> done after 1536 cycles, err_cnt=0, pass=1, fail_valid=0.
REQ-029 SHALL cover: DUT dut_s[0] stuck at 0 -> err_cnt=256, pass=0, first fail a=0, b=1, in_c=0 (with macro).
REQ-030 SHALL cover: DUT dut_zero inverted -> err_cnt=512, first fail a=0, b=0, in_c=0.
REQ-031 SHALL cover: start pulsed again at cycle 100 of a sweep -> ignored, done still at cycle 1536, single sweep.
REQ-032 SHALL cover: rst_n low at cycle 700 -> all outputs zero next check, IDLE; new start -> full clean sweep, err_cnt=0.
REQ-033 SHALL cover: SETTLE=3 with correct DUT -> done after 2560 cycles, pass=1.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub BIST: operand and counter widths, the
// sweep length, the controller state encoding and the DUT response record.
package add_sub_pkg;

  localparam int unsigned OP_W     = 4;                 // operand width
  localparam int unsigned VEC_CNT  = 512;               // {in_c, a, b} combinations
  localparam int unsigned VEC_W    = $clog2(VEC_CNT);   // 9-bit vector index
  localparam int unsigned ERR_W    = 10;                // holds 0..512 without wrap
  localparam int unsigned SETTLE_W = 4;                 // settle count 1..15

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_e;

  // One adder/subtractor response; the field order matches the compare concat.
  typedef struct packed {
    logic [OP_W-1:0] s;
    logic            overflow;
    logic            zero;
    logic            out_c;
  } result_t;

endpackage : add_sub_pkg

// File: rtl/add_sub_ref.sv
// Golden model of the 4-bit adder/subtractor. Subtraction is a + ~b + 1, so
// out_c is the carry out (1 = no borrow) and overflow is two's-complement.
module add_sub_ref
  import add_sub_pkg::*;
(
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  input  logic            in_c_i,
  output result_t         exp_o
);

  logic [OP_W-1:0] b_eff;
  logic [OP_W:0]   sum;

  assign b_eff = in_c_i ? ~b_i : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{OP_W{1'b0}}, in_c_i};

  assign exp_o.s        = sum[OP_W-1:0];
  assign exp_o.out_c    = sum[OP_W];
  // Same-sign operands producing an opposite-sign result is signed overflow.
  assign exp_o.overflow = (a_i[OP_W-1] == b_eff[OP_W-1]) &&
                          (sum[OP_W-1] != a_i[OP_W-1]);
  assign exp_o.zero     = (sum[OP_W-1:0] == '0);

endmodule : add_sub_ref

// File: rtl/add_sub_bist.sv
// Exhaustive BIST controller for a 4-bit adder/subtractor. Sweeps all 512
// {in_c, a, b} vectors, waits SETTLE cycles per vector, compares the response
// against add_sub_ref and counts failing vectors.
// Optional feature: define ADD_SUB_BIST_FIRST_FAIL_EN to capture the operands
// of the first failing vector of each sweep on fail_a/fail_b/fail_in_c.
module add_sub_bist
  import add_sub_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [OP_W-1:0]  dut_a,
  output logic [OP_W-1:0]  dut_b,
  output logic             dut_in_c,
  input  logic [OP_W-1:0]  dut_s,
  input  logic             dut_overflow,
  input  logic             dut_zero,
  input  logic             dut_out_c,
  output logic [OP_W-1:0]  fail_a,
  output logic [OP_W-1:0]  fail_b,
  output logic             fail_in_c,
  output logic             fail_valid
);

  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);
  localparam logic [VEC_W-1:0]    VEC_LAST = VEC_W'(VEC_CNT - 1);

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0]    err_q, err_d;

  result_t exp_res;
  result_t obs_res;
  logic    mismatch;
  logic    fail_hit;
  logic    sweep_start;

  // Operands come straight from the vector index, so they stay put from
  // DRIVE through CHECK without a separate holding register.
  assign dut_in_c = vec_q[VEC_W-1];
  assign dut_a    = vec_q[2*OP_W-1:OP_W];
  assign dut_b    = vec_q[OP_W-1:0];

  add_sub_ref u_ref (
    .a_i    (dut_a),
    .b_i    (dut_b),
    .in_c_i (dut_in_c),
    .exp_o  (exp_res)
  );

  assign obs_res     = {dut_s, dut_overflow, dut_zero, dut_out_c};
  assign mismatch    = (obs_res != exp_res);
  assign fail_hit    = (state_q == CHECK) && mismatch;
  assign sweep_start = start && ((state_q == IDLE) || (state_q == DONE));

  assign busy    = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done    = (state_q == DONE);
  assign pass    = done && (err_q == '0);
  assign err_cnt = err_q;

  // Controller state, vector index, settle counter and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: one vector is DRIVE, SETTLE x WAIT, then CHECK.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (sweep_start) begin
          state_d = DRIVE;
          vec_d   = '0;
          err_d   = '0;
        end
      end
      DRIVE: begin
        state_d  = WAIT;
        settle_d = SETTLE_W'(1);
      end
      WAIT: begin
        if (settle_q >= SETTLE_L) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      CHECK: begin
        // At most 512 increments per sweep, so the 10-bit count never wraps.
        if (fail_hit) begin
          err_d = err_q + ERR_W'(1);
        end
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + VEC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADD_SUB_BIST_FIRST_FAIL_EN
  logic [OP_W-1:0] fail_a_q;
  logic [OP_W-1:0] fail_b_q;
  logic            fail_in_c_q;
  logic            fail_valid_q;

  // First-failure capture: armed on each accepted start, frozen after one hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_in_c_q  <= 1'b0;
      fail_valid_q <= 1'b0;
    end else if (sweep_start) begin
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_in_c_q  <= 1'b0;
      fail_valid_q <= 1'b0;
    end else if (fail_hit && !fail_valid_q) begin
      fail_a_q     <= dut_a;
      fail_b_q     <= dut_b;
      fail_in_c_q  <= dut_in_c;
      fail_valid_q <= 1'b1;
    end
  end

  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_in_c  = fail_in_c_q;
  assign fail_valid = fail_valid_q;
`else
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_in_c  = 1'b0;
  assign fail_valid = 1'b0;
`endif

endmodule : add_sub_bist

// File: tb/tb_add_sub_bist.sv
// Directed bench for add_sub_bist: a behavioural adder/subtractor with
// selectable faults answers the BIST; one task per scenario.
module tb_add_sub_bist;

  logic clk = 1'b0;
  logic rst_n;
  int   fault;

  // Instance with SETTLE=1
  logic       start, busy, done, pass;
  logic [9:0] err_cnt;
  logic [3:0] dut_a, dut_b, dut_s, fail_a, fail_b;
  logic       dut_in_c, dut_overflow, dut_zero, dut_out_c, fail_in_c, fail_valid;

  // Instance with SETTLE=3
  logic       start3, busy3, done3, pass3;
  logic [9:0] err_cnt3;
  logic [3:0] dut_a3, dut_b3, dut_s3, fail_a3, fail_b3;
  logic       dut_in_c3, dut_overflow3, dut_zero3, dut_out_c3, fail_in_c3, fail_valid3;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  // Behavioural adder/subtractor using signed/unsigned integer arithmetic.
  // fault 1: s[0] stuck at 0; fault 2: zero flag inverted.
  function automatic logic [6:0] dut_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic c, input int flt);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] s;
    logic ov, z, co;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (!c) begin
      r  = ua + ub;
      co = (r > 15);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end
    ov = (sr > 7) || (sr < -8);
    s  = r[3:0];
    z  = (s == 4'd0);
    if (flt == 1) s[0] = 1'b0;
    if (flt == 2) z = ~z;
    return {s, ov, z, co};
  endfunction

  always_comb {dut_s, dut_overflow, dut_zero, dut_out_c} = dut_model(dut_a, dut_b, dut_in_c, fault);
  always_comb {dut_s3, dut_overflow3, dut_zero3, dut_out_c3} = dut_model(dut_a3, dut_b3, dut_in_c3, 0);

  add_sub_bist #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .dut_a(dut_a), .dut_b(dut_b), .dut_in_c(dut_in_c),
    .dut_s(dut_s), .dut_overflow(dut_overflow), .dut_zero(dut_zero), .dut_out_c(dut_out_c),
    .fail_a(fail_a), .fail_b(fail_b), .fail_in_c(fail_in_c), .fail_valid(fail_valid)
  );

  add_sub_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err_cnt3), .dut_a(dut_a3), .dut_b(dut_b3), .dut_in_c(dut_in_c3),
    .dut_s(dut_s3), .dut_overflow(dut_overflow3), .dut_zero(dut_zero3), .dut_out_c(dut_out_c3),
    .fail_a(fail_a3), .fail_b(fail_b3), .fail_in_c(fail_in_c3), .fail_valid(fail_valid3)
  );

  // Pulses start, then counts edges after the accepting edge until done.
  // Optionally re-pulses start at cycle ignore_at and samples operands at probe_at.
  task automatic run_sweep(input bit use3, input int ignore_at, input int probe_at,
                           output int cycles, output logic [8:0] probe);
    logic d, b;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
    cycles = 0;
    probe  = '0;
    while (cycles < 4000) begin
      @(posedge clk);
      #1;
      cycles++;
      d = use3 ? done3 : done;
      b = use3 ? busy3 : busy;
      if (d && b) overlap++;
      if (cycles == probe_at) probe = {dut_in_c, dut_a, dut_b};
      start = (cycles == ignore_at);
      if (d) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    fault  = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, pass, err_cnt, dut_a, dut_b, dut_in_c} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%0d a=%h b=%h c=%b, expected all 0",
               busy, done, pass, err_cnt, dut_a, dut_b, dut_in_c);
    end
    n_checks++;
    if ({fail_valid, fail_a, fail_b, fail_in_c} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_fail_regs: got v=%b a=%h b=%h c=%b, expected all 0",
               fail_valid, fail_a, fail_b, fail_in_c);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy, done, busy3, done3} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got busy=%b done=%b busy3=%b done3=%b, expected 0000",
               busy, done, busy3, done3);
    end
  endtask

  task automatic test_clean_sweep();
    int cyc;
    logic [8:0] pr;
    fault   = 0;
    overlap = 0;
    run_sweep(1'b0, -1, 1264, cyc, pr);
    n_checks++;
    if (cyc !== 1536) begin
      n_fail++;
      $display("FAIL clean_latency: got %0d cycles, expected 1536", cyc);
    end
    n_checks++;
    if (pr !== 9'h1A5) begin
      n_fail++;
      $display("FAIL clean_vector_order: got {c,a,b}=%h at cycle 1264, expected 1a5", pr);
    end
    n_checks++;
    if (err_cnt !== 10'd0 || pass !== 1'b1 || fail_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_result: got err=%0d pass=%b fv=%b, expected err=0 pass=1 fv=0",
               err_cnt, pass, fail_valid);
    end
    n_checks++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL clean_busy_done_overlap: got %0d overlapping cycles, expected 0", overlap);
    end
  endtask

  task automatic test_stuck_s0();
    int cyc;
    logic [8:0] pr;
    fault = 1;
    run_sweep(1'b0, -1, -1, cyc, pr);
    n_checks++;
    if (cyc !== 1536 || err_cnt !== 10'd256 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_s0_count: got cyc=%0d err=%0d pass=%b, expected 1536/256/0",
               cyc, err_cnt, pass);
    end
    n_checks++;
`ifdef ADD_SUB_BIST_FIRST_FAIL_EN
    if ({fail_valid, fail_in_c, fail_a, fail_b} !== 10'b1_0_0000_0001) begin
      n_fail++;
      $display("FAIL stuck_s0_first: got v=%b c=%b a=%h b=%h, expected v=1 c=0 a=0 b=1",
               fail_valid, fail_in_c, fail_a, fail_b);
    end
`else
    if ({fail_valid, fail_in_c, fail_a, fail_b} !== 10'd0) begin
      n_fail++;
      $display("FAIL stuck_s0_first: got v=%b c=%b a=%h b=%h, expected all 0",
               fail_valid, fail_in_c, fail_a, fail_b);
    end
`endif
  endtask

  task automatic test_zero_inverted();
    int cyc;
    logic [8:0] pr;
    fault = 2;
    run_sweep(1'b0, -1, -1, cyc, pr);
    n_checks++;
    if (cyc !== 1536 || err_cnt !== 10'd512 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_inv_count: got cyc=%0d err=%0d pass=%b, expected 1536/512/0",
               cyc, err_cnt, pass);
    end
    n_checks++;
`ifdef ADD_SUB_BIST_FIRST_FAIL_EN
    if ({fail_valid, fail_in_c, fail_a, fail_b} !== 10'b1_0_0000_0000) begin
      n_fail++;
      $display("FAIL zero_inv_first: got v=%b c=%b a=%h b=%h, expected v=1 c=0 a=0 b=0",
               fail_valid, fail_in_c, fail_a, fail_b);
    end
`else
    if ({fail_valid, fail_in_c, fail_a, fail_b} !== 10'd0) begin
      n_fail++;
      $display("FAIL zero_inv_first: got v=%b c=%b a=%h b=%h, expected all 0",
               fail_valid, fail_in_c, fail_a, fail_b);
    end
`endif
  endtask

  // Restart from DONE after a failing sweep; a second start at cycle 100 is ignored.
  task automatic test_start_ignored();
    int cyc;
    logic [8:0] pr;
    fault = 0;
    run_sweep(1'b0, 100, -1, cyc, pr);
    n_checks++;
    if (cyc !== 1536) begin
      n_fail++;
      $display("FAIL ignore_start_latency: got %0d cycles, expected 1536", cyc);
    end
    n_checks++;
    if (err_cnt !== 10'd0 || pass !== 1'b1 || fail_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_cleared: got err=%0d pass=%b fv=%b, expected 0/1/0",
               err_cnt, pass, fail_valid);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_single: got done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic [8:0] pr;
    fault = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    n_checks++;
    if (err_cnt !== 10'd233 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_progress: got err=%0d busy=%b, expected err=233 busy=1", err_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pass, err_cnt, dut_a, dut_b, dut_in_c, fail_valid, fail_a, fail_b, fail_in_c} !== 34'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got busy=%b done=%b err=%0d a=%h b=%h c=%b fv=%b, expected all 0",
               busy, done, err_cnt, dut_a, dut_b, dut_in_c, fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fault = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dut_a !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_no_resume: got busy=%b done=%b a=%h, expected 0/0/0", busy, done, dut_a);
    end
    run_sweep(1'b0, -1, -1, cyc, pr);
    n_checks++;
    if (cyc !== 1536 || err_cnt !== 10'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_new_sweep: got cyc=%0d err=%0d pass=%b, expected 1536/0/1",
               cyc, err_cnt, pass);
    end
  endtask

  task automatic test_settle3();
    int cyc;
    logic [8:0] pr;
    overlap = 0;
    run_sweep(1'b1, -1, -1, cyc, pr);
    n_checks++;
    if (cyc !== 2560) begin
      n_fail++;
      $display("FAIL settle3_latency: got %0d cycles, expected 2560", cyc);
    end
    n_checks++;
    if (err_cnt3 !== 10'd0 || pass3 !== 1'b1 || busy3 !== 1'b0 || overlap !== 0) begin
      n_fail++;
      $display("FAIL settle3_result: got err=%0d pass=%b busy=%b overlap=%0d, expected 0/1/0/0",
               err_cnt3, pass3, busy3, overlap);
    end
    n_checks++;
    if ({fail_valid3, fail_a3, fail_b3, fail_in_c3} !== 10'd0) begin
      n_fail++;
      $display("FAIL settle3_fail_regs: got v=%b a=%h b=%h c=%b, expected all 0",
               fail_valid3, fail_a3, fail_b3, fail_in_c3);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_stuck_s0();
    test_zero_inverted();
    test_start_ignored();
    test_mid_reset();
    test_settle3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add_sub_bist
